// File: rtl/calc_resp_sched.sv
// calc_resp_sched: merges the add/sub (source 1) and shift (source 2) response
// streams onto one output port. Each source has its own small FIFO so that
// same-cycle responses are serialised instead of colliding. Ties between the
// two sources are broken round-robin.

// Per-source response FIFO: DEPTH entries of {resp, data}, head always visible.
module calc_resp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              push,
    input  logic [0:1]        push_resp,
    input  logic [0:DATA_W-1] push_data,
    input  logic              pop,
    output logic [0:1]        head_resp,
    output logic [0:DATA_W-1] head_data,
    output logic [AW:0]       count
);

    logic [DEPTH-1:0][0:1]        mem_resp;
    logic [DEPTH-1:0][0:DATA_W-1] mem_data;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;

    assign head_resp = mem_resp[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Storage is write-only state; an empty FIFO's head is never used.
    always_ff @(posedge c_clk) begin
        if (push) begin
            mem_resp[wr_ptr] <= push_resp;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count is one bit wider.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// Top: per-source queueing, round-robin arbitration, one registered output.
module calc_resp_sched #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [0:1]        req_resp1,
    input  logic [0:DATA_W-1] req_data1,
    input  logic [0:1]        req_resp2,
    input  logic [0:DATA_W-1] req_data2,
    output logic [0:1]        out_resp,
    output logic [0:DATA_W-1] out_data,
    output logic              busy,
    output logic              ovf1,
    output logic              ovf2
);

    localparam int NUM_SRC = 2;
    localparam int AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [NUM_SRC-1:0][0:1]        in_resp;
    logic [NUM_SRC-1:0][0:DATA_W-1] in_data;
    logic [NUM_SRC-1:0][0:1]        head_resp;
    logic [NUM_SRC-1:0][0:DATA_W-1] head_data;
    logic [NUM_SRC-1:0][0:1]        cand_resp;
    logic [NUM_SRC-1:0][0:DATA_W-1] cand_data;
    logic [NUM_SRC-1:0][AW:0]       cnt;
    logic [NUM_SRC-1:0]             in_vld;
    logic [NUM_SRC-1:0]             empty;
    logic [NUM_SRC-1:0]             full;
    logic [NUM_SRC-1:0]             cand_vld;
    logic [NUM_SRC-1:0]             gnt;
    logic [NUM_SRC-1:0]             bypass;
    logic [NUM_SRC-1:0]             pop;
    logic [NUM_SRC-1:0]             push;
    logic [NUM_SRC-1:0]             drop;
    logic [NUM_SRC-1:0]             ovf;
    // 0: source 1 wins a tie; 1: source 2 wins a tie.
    logic                           pri;

    assign in_resp[0] = req_resp1;
    assign in_data[0] = req_data1;
    assign in_resp[1] = req_resp2;
    assign in_data[1] = req_data2;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            assign in_vld[g]   = |in_resp[g];
            assign empty[g]    = (cnt[g] == '0);
            assign full[g]     = (cnt[g] == FULL_CNT);
            // Queued entries always go first so a source never reorders itself.
            assign cand_vld[g]  = !empty[g] || in_vld[g];
            assign cand_resp[g] = empty[g] ? in_resp[g] : head_resp[g];
            assign cand_data[g] = empty[g] ? in_data[g] : head_data[g];
            assign bypass[g]    = gnt[g] && empty[g];
            assign pop[g]       = gnt[g] && !empty[g];
            // A full FIFO can still accept when its head leaves this cycle.
            assign push[g]      = in_vld[g] && !bypass[g] && (!full[g] || pop[g]);
            assign drop[g]      = in_vld[g] && !bypass[g] && full[g] && !pop[g];

            calc_resp_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .c_clk     (c_clk),
                .reset     (reset),
                .push      (push[g]),
                .push_resp (in_resp[g]),
                .push_data (in_data[g]),
                .pop       (pop[g]),
                .head_resp (head_resp[g]),
                .head_data (head_data[g]),
                .count     (cnt[g])
            );
        end
    endgenerate

    // Round-robin arbiter: a lone candidate wins, a tie goes to the side pri selects.
    always_comb begin
        gnt = '0;
        if (cand_vld[0] && (!cand_vld[1] || !pri))
            gnt[0] = 1'b1;
        else if (cand_vld[1])
            gnt[1] = 1'b1;
    end

    // Register the granted response, rotate priority, latch overflow flags.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            out_resp <= 2'b00;
            out_data <= '0;
            pri      <= 1'b0;
            ovf      <= '0;
        end else begin
            if (gnt[0]) begin
                out_resp <= cand_resp[0];
                out_data <= cand_data[0];
                pri      <= 1'b1;
            end else if (gnt[1]) begin
                out_resp <= cand_resp[1];
                out_data <= cand_data[1];
                pri      <= 1'b0;
            end else begin
                out_resp <= 2'b00;
                out_data <= '0;
            end
            ovf <= ovf | drop;
        end
    end

    assign busy = |cnt;
    assign ovf1 = ovf[0];
    assign ovf2 = ovf[1];

endmodule

// File: tb/tb_calc_resp_sched.sv
// Scoreboard bench for calc_resp_sched: stimulus pushes expected responses
// (with the cycle they must appear in), a negedge monitor pops and compares.
module tb_calc_resp_sched;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              c_clk = 1'b0;
    logic              reset;
    logic [0:1]        req_resp1, req_resp2;
    logic [0:DATA_W-1] req_data1, req_data2;
    logic [0:1]        out_resp;
    logic [0:DATA_W-1] out_data;
    logic              busy, ovf1, ovf2;

    calc_resp_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .req_resp1 (req_resp1),
        .req_data1 (req_data1),
        .req_resp2 (req_resp2),
        .req_data2 (req_data2),
        .out_resp  (out_resp),
        .out_data  (out_data),
        .busy      (busy),
        .ovf1      (ovf1),
        .ovf2      (ovf2)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:1]        resp;
        logic [0:DATA_W-1] data;
        int                at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    // Hand-computed output order for 12 cycles of dual input into DEPTH=4 FIFOs.
    int ovf_exp [20] = '{100, 200, 101, 201, 102, 202, 103, 203, 104, 204,
                         105, 205, 106, 206, 107, 207, 108, 209, 110, 211};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    // Expected response issued now, appearing off+1 edges later.
    task automatic expect_out(input logic [0:1] r, input logic [31:0] d, input int off);
        sb.push_back('{resp: r, data: d, at: cyc + 1 + off});
    endtask

    // Present inputs for exactly one rising edge, then return 1 ns after it.
    task automatic step(input logic [0:1] r1, input logic [31:0] d1,
                        input logic [0:1] r2, input logic [31:0] d2);
        req_resp1 = r1; req_data1 = d1;
        req_resp2 = r2; req_data2 = d2;
        @(posedge c_clk);
        #1;
        req_resp1 = 2'b00; req_data1 = '0;
        req_resp2 = 2'b00; req_data2 = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 0, 2'b00, 0);
    endtask

    // Monitor: every non-idle output must match the oldest expectation, on its cycle.
    always @(negedge c_clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (out_resp !== 2'b00) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got resp %b data %0h want none (cyc %0d)",
                             out_resp, out_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("out_resp", 64'(out_resp), 64'(e.resp));
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_cycle", 64'(cyc), 64'(e.at));
                end
            end else begin
                chk("idle_data", 64'(out_data), 64'd0);
            end
        end
    end

    initial begin
        // Reset held two edges with live inputs, which must be ignored.
        reset = 1'b1;
        req_resp1 = 2'b01; req_data1 = 32'hdead;
        req_resp2 = 2'b01; req_data2 = 32'hbeef;
        for (int k = 0; k < 2; k++) begin
            @(posedge c_clk);
            #1;
            chk("rst_resp", 64'(out_resp), 64'd0);
            chk("rst_data", 64'(out_data), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ovf1", 64'(ovf1), 64'd0);
            chk("rst_ovf2", 64'(ovf2), 64'd0);
        end
        mon_en = 1'b1;
        reset  = 1'b0;
        idle(1);
        chk("post_rst_resp", 64'(out_resp), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Single uncontended response: bypass, busy never rises.
        expect_out(2'b01, 4096, 0);
        step(2'b01, 4096, 2'b00, 0);
        chk("single_busy", 64'(busy), 64'd0);
        idle(1);

        // Source 2 single (code 11) hands the next tie back to source 1.
        expect_out(2'b11, 77, 0);
        step(2'b00, 0, 2'b11, 77);
        idle(1);

        // Collision: source 1 first, source 2 one cycle later from its FIFO.
        expect_out(2'b01, 4096, 0);
        expect_out(2'b10, 1234, 1);
        step(2'b01, 4096, 2'b10, 1234);
        chk("coll_busy_n1", 64'(busy), 64'd1);
        idle(1);
        chk("coll_busy_n2", 64'(busy), 64'd0);
        idle(1);

        // Fairness: a source 1 grant leaves priority with source 2 for the tie.
        expect_out(2'b01, 9, 0);
        step(2'b01, 9, 2'b00, 0);
        idle(1);
        expect_out(2'b01, 6, 0);
        expect_out(2'b01, 5, 1);
        step(2'b01, 5, 2'b01, 6);
        idle(2);

        // Source 2 single so the overflow burst starts with source 1 winning.
        expect_out(2'b11, 55, 0);
        step(2'b00, 0, 2'b11, 55);
        idle(1);

        // Overflow: 12 cycles dual input, then drain.
        for (int j = 0; j < 20; j++)
            expect_out((ovf_exp[j] < 200) ? 2'b11 : 2'b10, ovf_exp[j], j);
        for (int i = 0; i < 12; i++) begin
            step(2'b11, 100 + i, 2'b10, 200 + i);
            if (i == 8) begin
                chk("ovf2_first", 64'(ovf2), 64'd1);
                chk("ovf1_not_yet", 64'(ovf1), 64'd0);
            end
            if (i == 9) chk("ovf1_rise", 64'(ovf1), 64'd1);
        end
        chk("ovf1_burst_end", 64'(ovf1), 64'd1);
        chk("ovf2_burst_end", 64'(ovf2), 64'd1);
        idle(7);
        chk("drain_busy_last", 64'(busy), 64'd1);
        idle(1);
        chk("drain_busy_done", 64'(busy), 64'd0);
        chk("ovf1_sticky", 64'(ovf1), 64'd1);
        chk("ovf2_sticky", 64'(ovf2), 64'd1);
        idle(1);

        // Reset mid-drain: three outputs escape, the rest are discarded.
        expect_out(2'b01, 300, 0);
        expect_out(2'b10, 400, 1);
        expect_out(2'b01, 301, 2);
        for (int i = 0; i < 3; i++) step(2'b01, 300 + i, 2'b10, 400 + i);
        chk("middrain_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step(2'b01, 32'h77, 2'b01, 32'h88);
        reset = 1'b0;
        chk("mdr_resp", 64'(out_resp), 64'd0);
        chk("mdr_data", 64'(out_data), 64'd0);
        chk("mdr_busy", 64'(busy), 64'd0);
        chk("mdr_ovf1", 64'(ovf1), 64'd0);
        chk("mdr_ovf2", 64'(ovf2), 64'd0);
        idle(1);
        chk("mdr_busy2", 64'(busy), 64'd0);

        // Priority restored by reset: source 1 wins the tie.
        expect_out(2'b01, 32'hA, 0);
        expect_out(2'b10, 32'hB, 1);
        step(2'b01, 32'hA, 2'b10, 32'hB);
        idle(3);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_resp_sched.md
# calc_resp_sched

Response scheduler for the calc datapath. Two result sources (add/sub unit on port 1, shift unit on port 2) each emit single-cycle responses with no backpressure. This block queues them per source and serialises them onto one shared output response port, at most one response per cycle, with round-robin fairness. It replaces the combinational OR-merge, which assumes the sources never respond in the same cycle.

## Interface
- DATA_W, 32, response data width
- DEPTH, 4, entries per source FIFO; power of two, ≥2

- c_clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on c_clk rising edge
- req_resp1  in  [0:1]  source 1 response code; 2'b00 = no response, any other value = response valid this cycle
- req_data1  in  [0:DATA_W-1]  source 1 data, qualified by req_resp1 != 0
- req_resp2  in  [0:1]  source 2 response code, same encoding
- req_data2  in  [0:DATA_W-1]  source 2 data
- out_resp  out  [0:1]  scheduled response code; 2'b00 when idle
- out_data  out  [0:DATA_W-1]  scheduled data; all zero when out_resp == 0
- busy  out  1  high while either FIFO is non-empty
- ovf1  out  1  sticky: a source 1 response was dropped
- ovf2  out  1  sticky: a source 2 response was dropped

## Operation
- Per source i: FIFO of DEPTH entries, each holding {resp, data}. Count width is log2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
- Candidate for source i in a cycle: FIFO head if the FIFO is non-empty, otherwise the incoming response when req_respi != 0. An incoming response never overtakes queued entries of its own source.
- Arbiter: 1-bit priority pointer `pri` (0 = source 1 first). If only one candidate exists, it is granted. If both exist, source (pri+1) is granted. After any grant to source k, `pri` is set to k so the other source wins the next tie.
- Granted candidate is registered to out_resp/out_data. If it was the FIFO head, that entry is popped. If it was the incoming response, it bypasses the FIFO.
- Incoming response not granted is pushed. A push is allowed when count < DEPTH, or when count == DEPTH and the head is popped in the same cycle.
- Drop: incoming response, not granted, and FIFO full with no pop in that cycle. The response is discarded, ovfi is set to 1, and FIFO contents are unchanged.
- Response codes pass through unmodified (01, 10, 11 all valid). Data is never altered.
- ovf1/ovf2 clear only on reset.

## Timing
- Reset values, visible the cycle after reset is sampled high: out_resp = 2'b00, out_data = 0, busy = 0, ovf1 = ovf2 = 0, pri = 0, both FIFOs empty. Inputs are ignored while reset is high.
- Latency: an uncontended response sampled at edge N appears on out_* during cycle N+1 (one register stage).
- Each output response is a single-cycle pulse. Back-to-back grants give consecutive non-zero cycles. Idle cycles drive 00/0.
- Throughput: one response per cycle total. Sustained dual input at one per cycle per source overflows by design.
- busy reflects FIFO counts after the edge. Bypassed responses never raise busy.
- Reset mid-operation: all queued entries are discarded with no output pulse, and the state above is restored on the next edge.

## Test plan
- Reset: hold reset 2 cycles with req_resp1 = 01, req_resp2 = 01 -> out_resp = 00, out_data = 0, busy = 0, ovf1 = ovf2 = 0 throughout, and 00 on the first cycle after release.
- Single: req_resp1 = 01, req_data1 = 4096 for one cycle at N -> out_resp = 01, out_data = 4096 in cycle N+1 only; busy stays 0.
- Collision: at N, source 1 = 01/4096 and source 2 = 10/1234 -> N+1: 01/4096; N+2: 10/1234; busy = 1 during N+1 only.
- Fairness: after the collision test, a second collision 01/5 and 01/6 -> source 2 (6) is granted first, then 5.
- Overflow (DEPTH = 4): both sources valid with distinct incrementing data for 12 consecutive cycles -> outputs alternate sources; per-source data order is strictly increasing; ovf1 and ovf2 both rise and stay high; busy falls after the last queued entry drains.
- Reset mid-drain: both FIFOs non-empty, pulse reset 1 cycle -> next cycle out_resp = 00, busy = 0, ovf cleared; a subsequent collision grants source 1 first.
